ca_sequencer: RTL
=================

CA_SEQUENCER -- requirements
Module: ca_sequencer

Interface
REQ-001 SHALL have parameter ENTRY_PC, default 12'h000, program counter loaded at each generation start.
REQ-002 SHALL have parameter RSTACK_DEPTH, default 32, return-stack entries; fixed to match the 5-bit stack pointer.
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-006 SHALL have port generations, input, 16, generations to run per start; sampled with start.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when a run completes.
REQ-009 SHALL have port gen_count, output, 16, generations completed in the current run.
REQ-010 SHALL have port imem_addr, output, 12, instruction memory read address.
REQ-011 SHALL have port imem_rdata, input, 16, instruction word, valid one cycle after imem_addr.
REQ-012 SHALL have port instruction, output, 16, broadcast word to the cell array.
REQ-013 SHALL have port next_program_counter, output, 12, successor PC broadcast to cells.
REQ-014 SHALL have port next_stack_pointer, output, 5, successor stack pointer broadcast to cells.
REQ-015 SHALL have port execution_enable, output, 1, cell array commit strobe.
REQ-016 SHALL have port diverge_consensus, input, 1, AND of all cell diverge flags.
REQ-017 SHALL have port stack_error, output, 1, sticky return-stack overflow/underflow flag.

Function
REQ-018 SHALL implement states IDLE, FETCH, DECODE, EXEC, DONE; one instruction per FETCH->DECODE->EXEC cycle triple.
REQ-019 SHALL, in IDLE with start=1 and generations!=0, load pc=ENTRY_PC, sp=0, gen_count=0, clear stack_error, go FETCH.
REQ-020 SHALL, in IDLE with start=1 and generations==0, go DONE without fetching.
REQ-021 SHALL ignore start whenever busy=1.
REQ-022 SHALL drive imem_addr=pc in FETCH, then go DECODE.
REQ-023 SHALL, in DECODE, register imem_rdata into instruction, compute and register next_program_counter and next_stack_pointer, go EXEC.
REQ-024 SHALL decode the opcode from instruction[15:12]; target is instruction[11:0].
REQ-025 SHALL treat opcode 4'hE (BRA) as: next pc = target if diverge_consensus==1 (sampled in DECODE), else pc+1.
REQ-026 SHALL treat 4'hD (CALL) as: push pc+1 at rstack[sp], sp+1, next pc = target.
REQ-027 SHALL treat 4'hC (RET) as: sp-1, next pc = rstack[sp-1].
REQ-028 SHALL treat CALL at sp==31 as overflow: no push, sp unchanged, next pc = pc+1, stack_error=1.
REQ-029 SHALL treat RET at sp==0 as underflow: sp unchanged, next pc = pc+1, stack_error=1.
REQ-030 SHALL treat all other opcodes except 4'hF as cell ops: next pc = pc+1, sp unchanged.
REQ-031 SHALL wrap pc+1 modulo 4096 (12'hFFF -> 12'h000).
REQ-032 SHALL assert execution_enable for exactly the EXEC cycle of every non-HALT instruction, then load pc/sp from the next_* registers and go FETCH.
REQ-033 SHALL treat 4'hF (HALT) as generation end: execution_enable stays 0, gen_count+1; if the new gen_count==generations, go DONE, else pc=ENTRY_PC, sp=0, go FETCH.
REQ-034 SHALL, in DONE, pulse done for one cycle and return to IDLE; gen_count holds its value until the next accepted start.
REQ-035 SHALL hold instruction, next_program_counter and next_stack_pointer stable from DECODE through the end of EXEC.

Reset
REQ-036 SHALL, on rst=1 in any state, immediately force IDLE, busy=0, done=0, execution_enable=0, instruction=0, next_program_counter=0, next_stack_pointer=0, imem_addr=0, gen_count=0, stack_error=0, pc=0, sp=0.
REQ-037 SHALL NOT require reset of return-stack storage contents.

Verification
REQ-038 SHALL verify one generation: imem {0:16'h1234, 1:16'hF000}, start, generations=1 -> execution_enable once with instruction=16'h1234, next_program_counter=1; done 7 cycles after start; gen_count=1.
REQ-039 SHALL verify branching: BRA 12'h010 at 0 with diverge_consensus=1 -> next_program_counter=12'h010; repeat with 0 -> 12'h001.
REQ-040 SHALL verify CALL 12'h020 at 5 then RET at 12'h020 -> next_stack_pointer 1 then 0; next_program_counter 12'h020 then 12'h006.
REQ-041 SHALL verify 32 nested CALLs -> 32nd sets stack_error, next_stack_pointer stays 31; RET at sp=0 also sets stack_error.
REQ-042 SHALL verify generations=3 -> three HALTs, gen_count 3, single done pulse; generations=0 -> done without execution_enable.
REQ-043 SHALL verify rst asserted in EXEC -> execution_enable and busy drop same cycle, all outputs zero, next start runs cleanly.

Source files
------------

// File: rtl/ca_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ca_sequencer_if
// Purpose  : Instruction-memory port and cell-array broadcast bus of the
//            cellular-automaton sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ca_sequencer_if;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic [11:0] next_program_counter;
    logic [4:0]  next_stack_pointer;
    logic        execution_enable;
    logic        diverge_consensus;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output instruction,
        output next_program_counter,
        output next_stack_pointer,
        output execution_enable,
        input  diverge_consensus
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  instruction,
        input  next_program_counter,
        input  next_stack_pointer,
        input  execution_enable,
        output diverge_consensus
    );
endinterface
`default_nettype wire

// File: rtl/ca_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ca_sequencer
// Purpose  : Fetch/decode/execute sequencer broadcasting one instruction per
//            three cycles to a SIMD cell array, with a call/return stack.
// Revision : 1.0 - initial release
// ============================================================================
module ca_sequencer #(
    parameter logic [11:0] ENTRY_PC     = 12'h000,
    parameter int          RSTACK_DEPTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [15:0]    generations,
    output logic           busy,
    output logic           done,
    output logic [15:0]    gen_count,
    output logic           stack_error,
    ca_sequencer_if.master bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [3:0] c_OP_RET  = 4'hC;
    localparam logic [3:0] c_OP_CALL = 4'hD;
    localparam logic [3:0] c_OP_BRA  = 4'hE;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    localparam logic [4:0] c_SP_MAX = 5'd31;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [11:0] r_pc;
    logic [4:0]  r_sp;
    logic [15:0] r_instruction;
    logic [11:0] r_next_pc;
    logic [4:0]  r_next_sp;
    logic [15:0] r_gen_count;
    logic [15:0] r_generations;
    logic        r_stack_error;
    logic [11:0] r_rstack [RSTACK_DEPTH];

    logic [3:0]  w_opcode;
    logic [11:0] w_target;
    logic [11:0] w_pc_inc;
    logic [4:0]  w_sp_dec;
    logic [11:0] w_next_pc;
    logic [4:0]  w_next_sp;
    logic        w_push;
    logic        w_stack_fault;
    logic        w_exec_halt;
    logic [15:0] w_gen_inc;
    logic        w_last_gen;
    logic        w_exec_en;

    // Decode looks at the raw memory word; EXEC looks at the latched copy.
    assign w_opcode    = bus.imem_rdata[15:12];
    assign w_target    = bus.imem_rdata[11:0];
    assign w_pc_inc    = r_pc + 12'd1;
    assign w_sp_dec    = r_sp - 5'd1;
    assign w_exec_halt = (r_instruction[15:12] == c_OP_HALT);
    assign w_gen_inc   = r_gen_count + 16'd1;
    assign w_last_gen  = (w_gen_inc == r_generations);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        w_exec_en    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (generations == 16'd0) ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_FETCH:  w_state_next = c_ST_DECODE;
            c_ST_DECODE: w_state_next = c_ST_EXEC;
            c_ST_EXEC: begin
                if (w_exec_halt) begin
                    w_state_next = w_last_gen ? c_ST_DONE : c_ST_FETCH;
                end else begin
                    w_exec_en    = 1'b1;
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_DONE: begin
                done         = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_next_pc     = w_pc_inc;
        w_next_sp     = r_sp;
        w_push        = 1'b0;
        w_stack_fault = 1'b0;
        case (w_opcode)
            c_OP_BRA: begin
                if (bus.diverge_consensus) begin
                    w_next_pc = w_target;
                end
            end
            c_OP_CALL: begin
                // The top slot is never filled: a full stack reads as sp==31.
                if (r_sp == c_SP_MAX) begin
                    w_stack_fault = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_next_sp = r_sp + 5'd1;
                    w_next_pc = w_target;
                end
            end
            c_OP_RET: begin
                if (r_sp == 5'd0) begin
                    w_stack_fault = 1'b1;
                end else begin
                    w_next_sp = w_sp_dec;
                    w_next_pc = r_rstack[w_sp_dec];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if ((r_state == c_ST_DECODE) && w_push) begin
            r_rstack[r_sp] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= 12'd0;
            r_sp          <= 5'd0;
            r_instruction <= 16'd0;
            r_next_pc     <= 12'd0;
            r_next_sp     <= 5'd0;
            r_gen_count   <= 16'd0;
            r_generations <= 16'd0;
            r_stack_error <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_gen_count   <= 16'd0;
                        r_generations <= generations;
                        if (generations != 16'd0) begin
                            r_pc          <= ENTRY_PC;
                            r_sp          <= 5'd0;
                            r_stack_error <= 1'b0;
                        end
                    end
                end
                c_ST_DECODE: begin
                    r_instruction <= bus.imem_rdata;
                    r_next_pc     <= w_next_pc;
                    r_next_sp     <= w_next_sp;
                    if (w_stack_fault) begin
                        r_stack_error <= 1'b1;
                    end
                end
                c_ST_EXEC: begin
                    if (w_exec_halt) begin
                        r_gen_count <= w_gen_inc;
                        if (!w_last_gen) begin
                            r_pc <= ENTRY_PC;
                            r_sp <= 5'd0;
                        end
                    end else begin
                        r_pc <= r_next_pc;
                        r_sp <= r_next_sp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gen_count                = r_gen_count;
    assign stack_error              = r_stack_error;
    assign bus.imem_addr            = r_pc;
    assign bus.instruction          = r_instruction;
    assign bus.next_program_counter = r_next_pc;
    assign bus.next_stack_pointer   = r_next_sp;
    assign bus.execution_enable     = w_exec_en;

endmodule
`default_nettype wire
